// File: rtl/dram_read_arb.sv
// Two-requester round-robin arbiter in front of a single DRAM reader: ack one cycle after req, kick one cycle after ack.
// A new grant waits for IDLE with busy low; reader strobes are steered to the owner, and a reader that never goes busy is aborted.
module dram_read_arb #(
  parameter int          BUSY_TIMEOUT = 255,
  parameter logic [31:0] MAX_NUM      = 32'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] num0,
  input  logic [31:0] num1,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        kick,
  input  logic        busy,
  output logic [31:0] read_addr,
  output logic [31:0] read_num,
  input  logic        buf_we,
  output logic [1:0]  we_out,
  output logic        owner,
  output logic        active
);

  localparam int CW = ($clog2(BUSY_TIMEOUT + 1) > 8) ? $clog2(BUSY_TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    ack_nxt, done_nxt, err_nxt;
  logic          kick_nxt, owner_nxt;
  logic [31:0]   addr_nxt, num_nxt;
  logic          g;
  logic [31:0]   g_addr, g_num;
  logic          timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= '0;
      done      <= '0;
      err       <= '0;
      kick      <= 1'b0;
      owner     <= 1'b1;
      read_addr <= '0;
      read_num  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ack       <= ack_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      kick      <= kick_nxt;
      owner     <= owner_nxt;
      read_addr <= addr_nxt;
      read_num  <= num_nxt;
    end
  end

  always_comb begin
    // With both requesting, the one that did not win last time goes next.
    g           = (req == 2'b11) ? ~owner : ~req[0];
    g_addr      = g ? addr1 : addr0;
    g_num       = g ? num1 : num0;
    timeout_hit = ({1'b0, cnt} + (CW+1)'(1)) >= (CW+1)'(BUSY_TIMEOUT);

    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = '0;
    done_nxt  = '0;
    err_nxt   = '0;
    kick_nxt  = 1'b0;
    owner_nxt = owner;
    addr_nxt  = read_addr;
    num_nxt   = read_num;

    case (state)
      IDLE: begin
        if ((req != 2'b00) && !busy) begin
          ack_nxt[g] = 1'b1;
          owner_nxt  = g;
          addr_nxt   = g_addr;
          num_nxt    = g_num;
          if ((g_num == 32'd0) || (g_num > MAX_NUM)) err_nxt[g] = 1'b1;
          else                                        state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        kick_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_nxt = RUN;
        end else if (timeout_hit) begin
          err_nxt[owner] = 1'b1;
          state_nxt      = IDLE;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!busy) begin
          done_nxt[owner] = 1'b1;
          state_nxt       = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we_out = '0;
    if ((state == WAIT_BUSY) || (state == RUN) || (state == DONE)) we_out[owner] = buf_we;
    active = (state != IDLE);
  end

endmodule

// File: tb/tb_dram_read_arb.sv
// Randomized bench for dram_read_arb: a cycle-stepped reader/requester model predicts grants and transfer totals.
module tb_dram_read_arb;
  localparam int          BT   = 20;
  localparam logic [31:0] MAXN = 32'd256;

  logic        clk = 1'b0;
  logic        rst, kick, busy, buf_we, owner, active;
  logic [1:0]  req, ack, done, err, we_out;
  logic [31:0] addr0, addr1, num0, num1, read_addr, read_num;

  always #5 clk = ~clk;

  dram_read_arb #(.BUSY_TIMEOUT(BT), .MAX_NUM(MAXN)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1), .num0(num0), .num1(num1),
    .ack(ack), .done(done), .err(err), .kick(kick), .busy(busy), .read_addr(read_addr),
    .read_num(read_num), .buf_we(buf_we), .we_out(we_out), .owner(owner), .active(active)
  );

  int checks = 0, failures = 0, cyc = 0, viol = 0;
  int ack_cnt[2], done_cnt[2], err_cnt[2], we_cnt[2], kick_cnt;
  int exp_we[2], exp_done[2], exp_err[2];
  int last_ack_cyc, last_kick_cyc, last_err_cyc;
  int rd_wait, rd_left;
  bit act_at_err, m_owner, outstanding, kicked;
  bit rd_go, rd_stall, rd_busy, busy_force, rd_rand;
  bit gq[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock: observe DUT, update the scoreboard, run the reader and requester models.
  task automatic step();
    logic [1:0]  req_smp;
    logic        busy_smp, rst_smp;
    bit          gi, ev, ei, di;
    logic [31:0] gn;
    req_smp  = req;
    busy_smp = busy;
    rst_smp  = rst;
    @(negedge clk);
    cyc++;
    if (rst_smp) begin
      outstanding = 0;
      kicked      = 0;
      m_owner     = 1;
    end else begin
      if (ack != 2'b00) begin
        if (($countones(ack) != 1) || busy_smp) viol++;
        gi = ack[1];
        chk("grant_idx", int'(gi), int'((req_smp == 2'b11) ? !m_owner : !req_smp[0]));
        gn = gi ? num1 : num0;
        ev = (gn == 32'd0) || (gn > MAXN);
        chk("grant_addr", int'(read_addr), int'(gi ? addr1 : addr0));
        chk("grant_num", int'(read_num), int'(gn));
        chk("grant_err", int'(err[gi]), int'(ev));
        m_owner = gi;
        gq.push_back(gi);
        ack_cnt[gi]++;
        last_ack_cyc = cyc;
        if (ev) exp_err[gi]++;
        else begin
          if (outstanding) viol++;
          outstanding = 1;
          exp_done[gi]++;
          exp_we[gi] += int'(gn);
        end
      end
      if (err != 2'b00) begin
        ei = err[1];
        err_cnt[ei]++;
        last_err_cyc = cyc;
        act_at_err   = active;
        if (ack == 2'b00) begin
          if (!kicked || (ei != m_owner)) viol++;
          outstanding = 0;
          kicked      = 0;
          rd_go       = 0;
        end
      end
      if (done != 2'b00) begin
        di = done[1];
        done_cnt[di]++;
        if (!kicked || (ack != 2'b00) || (di != m_owner)) viol++;
        outstanding = 0;
        kicked      = 0;
      end
      if ((err & done) != 2'b00) viol++;
      if (kick) begin
        kick_cnt++;
        last_kick_cyc = cyc;
        if (!outstanding || kicked) viol++;
        kicked = 1;
      end
    end
    we_cnt[0] += int'(we_out[0]);
    we_cnt[1] += int'(we_out[1]);
    if (&we_out) viol++;

    if (kick && !rst_smp) begin
      rd_go   = 1;
      rd_wait = rd_rand ? int'($urandom_range(1, 4)) : 2;
      rd_left = int'(read_num);
    end else if (rd_go && !rd_stall) begin
      if (rd_wait > 1) rd_wait--;
      else if (rd_left > 0) begin
        rd_busy = 1;
        buf_we  = 1'b1;
        rd_left--;
      end else begin
        rd_busy = 0;
        buf_we  = 1'b0;
        rd_go   = 0;
      end
    end
    busy = rd_busy | busy_force;
    for (int i = 0; i < 2; i++) if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (((req != 2'b00) || active || rd_go) && (n < 400)) begin
      step();
      n++;
    end
    chk(tag, int'(n < 400), 1);
  endtask

  initial begin
    int n, rc, k0, d0, d1, e0, e1, a0, a1, w0, w1, base, r;
    logic [3:0] order;
    rst = 1'b1; req = 2'b00; busy = 1'b0; buf_we = 1'b0;
    addr0 = '0; addr1 = '0; num0 = '0; num1 = '0;
    repeat (3) step();
    chk("rst_active", int'(active), 0);
    chk("rst_owner", int'(owner), 1);
    chk("rst_pulses", int'({ack, done, err, kick}), 0);
    chk("rst_we_out", int'(we_out), 0);
    chk("rst_read_addr", int'(read_addr), 0);
    chk("rst_read_num", int'(read_num), 0);
    rst = 1'b0;
    step();

    // Single transfer with minimum-latency timing.
    k0 = kick_cnt; d0 = done_cnt[0]; w0 = we_cnt[0]; w1 = we_cnt[1]; e0 = err_cnt[0];
    addr0 = 32'h1000; num0 = 32'd16; req[0] = 1'b1; rc = cyc;
    n = 0;
    while ((done_cnt[0] == d0) && (n < 200)) begin step(); n++; end
    chk("t1_timeout", int'(n < 200), 1);
    chk("t1_ack_lat", last_ack_cyc - rc, 1);
    chk("t1_kick_lat", last_kick_cyc - rc, 2);
    chk("t1_read_addr", int'(read_addr), 32'h1000);
    chk("t1_read_num", int'(read_num), 16);
    chk("t1_we0", we_cnt[0] - w0, 16);
    chk("t1_we1", we_cnt[1] - w1, 0);
    chk("t1_kicks", kick_cnt - k0, 1);
    chk("t1_done", done_cnt[0] - d0, 1);
    chk("t1_err", err_cnt[0] - e0, 0);
    wait_quiet("t1_quiet");

    // Both held: alternating grants from a fresh reset.
    do_reset();
    base = gq.size(); d0 = done_cnt[0]; d1 = done_cnt[1];
    num0 = 32'd4; num1 = 32'd4; addr0 = 32'hA000; addr1 = 32'hB000; req = 2'b11;
    n = 0;
    while ((done_cnt[0] + done_cnt[1] - d0 - d1 < 4) && (n < 400)) begin
      step();
      n++;
      if ((gq.size() - base + $countones(req)) < 4)
        for (int i = 0; i < 2; i++) if (!req[i]) begin req[i] = 1'b1; break; end
    end
    chk("t2_timeout", int'(n < 400), 1);
    order = '0;
    for (int i = 0; i < 4; i++) if (gq.size() > base + i) order[i] = gq[base + i];
    chk("t2_order", int'(order), int'(4'b1010));
    chk("t2_done0", done_cnt[0] - d0, 2);
    chk("t2_done1", done_cnt[1] - d1, 2);
    wait_quiet("t2_quiet");

    // Rejected word counts.
    k0 = kick_cnt; a1 = ack_cnt[1]; e1 = err_cnt[1];
    num1 = 32'd0; req[1] = 1'b1;
    wait_quiet("t3a_quiet");
    num1 = MAXN + 32'd1; req[1] = 1'b1;
    wait_quiet("t3b_quiet");
    chk("t3_ack1", ack_cnt[1] - a1, 2);
    chk("t3_err1", err_cnt[1] - e1, 2);
    chk("t3_kicks", kick_cnt - k0, 0);

    // Reader never goes busy.
    rd_stall = 1; d0 = done_cnt[0]; e0 = err_cnt[0];
    num0 = 32'd4; req[0] = 1'b1;
    n = 0;
    while ((err_cnt[0] == e0) && (n < BT + 40)) begin step(); n++; end
    chk("t4_timeout", int'(n < BT + 40), 1);
    chk("t4_err_lat", last_err_cyc - last_kick_cyc, BT);
    chk("t4_idle", int'(act_at_err), 0);
    chk("t4_done", done_cnt[0] - d0, 0);
    rd_stall = 0;
    wait_quiet("t4_quiet");

    // Reset in the middle of a run.
    num1 = 32'd20; req[1] = 1'b1; w1 = we_cnt[1];
    n = 0;
    while (!(busy && (we_cnt[1] - w1 >= 3)) && (n < 100)) begin step(); n++; end
    chk("t5_run_reached", int'(n < 100), 1);
    d1 = done_cnt[1]; e1 = err_cnt[1];
    rst = 1'b1;
    step();
    chk("t5_active", int'(active), 0);
    chk("t5_kick", int'(kick), 0);
    chk("t5_we_out", int'(we_out), 0);
    chk("t5_done_err", int'({done, err}), 0);
    rst = 1'b0;
    w1 = we_cnt[1];
    wait_quiet("t5_quiet");
    chk("t5_we_after", we_cnt[1] - w1, 0);
    chk("t5_no_done", done_cnt[1] - d1, 0);
    chk("t5_no_err", err_cnt[1] - e1, 0);

    // Grant held off while the reader is busy.
    busy_force = 1;
    step();
    a0 = ack_cnt[0]; d0 = done_cnt[0];
    num0 = 32'd3; req[0] = 1'b1;
    repeat (10) step();
    chk("t6_no_ack", ack_cnt[0] - a0, 0);
    busy_force = 0;
    wait_quiet("t6_quiet");
    chk("t6_ack", ack_cnt[0] - a0, 1);
    chk("t6_done", done_cnt[0] - d0, 1);

    // Random traffic against the scoreboard totals.
    rd_rand = 1;
    for (int i = 0; i < 2; i++) begin
      exp_we[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
    end
    w0 = we_cnt[0]; w1 = we_cnt[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
    e0 = err_cnt[0]; e1 = err_cnt[1];
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && ($urandom_range(0, 3) == 0)) begin
          r = int'($urandom_range(0, 9));
          if (i == 0) begin
            addr0 = $urandom;
            num0  = (r == 0) ? 32'd0 : (r == 1) ? MAXN + 32'd1 : 32'($urandom_range(1, 6));
          end else begin
            addr1 = $urandom;
            num1  = (r == 0) ? 32'd0 : (r == 1) ? MAXN + 32'd1 : 32'($urandom_range(1, 6));
          end
          req[i] = 1'b1;
        end
      end
    end
    wait_quiet("t7_quiet");
    chk("t7_we0", we_cnt[0] - w0, exp_we[0]);
    chk("t7_we1", we_cnt[1] - w1, exp_we[1]);
    chk("t7_done0", done_cnt[0] - d0, exp_done[0]);
    chk("t7_done1", done_cnt[1] - d1, exp_done[1]);
    chk("t7_err0", err_cnt[0] - e0, exp_err[0]);
    chk("t7_err1", err_cnt[1] - e1, exp_err[1]);
    chk("protocol_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_read_arb.md
DRAM_READ_ARB -- requirements
Module: dram_read_arb

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 255: max cycles from kick to busy rise before abort.
REQ-002 Parameter MAX_NUM, default 32'd256: largest accepted read_num (words).
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester read request level; held until ack.
REQ-006 addr0, addr1  input  32  byte address per requester.
REQ-007 num0, num1  input  32  word count per requester.
REQ-008 ack  output  2  one-cycle accept pulse per requester.
REQ-009 done  output  2  one-cycle completion pulse per requester.
REQ-010 err  output  2  one-cycle error pulse (rejected or timeout), never together with done.
REQ-011 kick  output  1  one-cycle start pulse to DRAM reader.
REQ-012 busy  input  1  DRAM reader busy.
REQ-013 read_addr  output  32  latched address to DRAM reader.
REQ-014 read_num  output  32  latched word count to DRAM reader.
REQ-015 buf_we  input  1  DRAM reader data-valid strobe.
REQ-016 we_out  output  2  buf_we steered to the current owner; other bit 0.
REQ-017 owner  output  1  index of current/last granted requester.
REQ-018 active  output  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, ISSUE, WAIT_BUSY, RUN, DONE; encoding free.
REQ-020 IDLE: if any req and busy==0, grant per round-robin, ack[g]=1 for one cycle, latch addr/num of g into read_addr/read_num, owner<=g, go ISSUE.
REQ-021 Round-robin: both req set -> grant index != owner; single req -> that index.
REQ-022 IDLE with busy==1: no grant, stay IDLE.
REQ-023 Grant with num==0 or num>MAX_NUM: ack[g] and err[g] pulse the same cycle, no kick, stay IDLE; owner still updates.
REQ-024 ISSUE: kick=1 exactly one cycle, go WAIT_BUSY, timeout counter cleared.
REQ-025 WAIT_BUSY: busy==1 -> RUN; counter reaching BUSY_TIMEOUT with busy==0 -> err[owner] pulse, IDLE.
REQ-026 RUN: stay while busy==1; busy==0 -> DONE.
REQ-027 DONE: done[owner]=1 one cycle, go IDLE; next grant no earlier than the following cycle.
REQ-028 we_out[owner]=buf_we combinationally in WAIT_BUSY, RUN, DONE; 0 otherwise; strobes in IDLE/ISSUE dropped.
REQ-029 read_addr/read_num stable from grant until next grant.
REQ-030 Requester deasserting req after ack has no effect on the transfer.
REQ-031 Minimum latency: req at cycle 0 -> ack cycle 1 (registered), kick cycle 2.
REQ-032 Timeout counter 8+ bits wide, saturating, never wraps.

Reset
REQ-033 rst: state IDLE; kick, ack, done, err, we_out, active = 0; owner=1 (requester 0 wins first tie); read_addr, read_num = 0; counter 0.
REQ-034 rst mid-transfer: abort immediately, no done/err pulse, buf_we strobes ignored until next grant.

Verification
REQ-035 req=2'b01, addr0=0x1000, num0=16; busy rises 2 cycles after kick, 16 buf_we, falls -> ack[0], kick once, read_addr=0x1000, read_num=16, we_out[0] 16 pulses, done[0] once.
REQ-036 req=2'b11 held, both num=4, reader model -> grants order 0,1,0,1; each ack paired with its done; no overlap of kicks before done.
REQ-037 req[1] with num1=0, then num1=MAX_NUM+1 -> ack[1]+err[1] same cycle, kick never asserted.
REQ-038 busy held 0 after kick -> err[owner] exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY, state IDLE, no done.
REQ-039 rst asserted during RUN with busy=1 -> next cycle active=0, kick=0, no done/err; we_out=0 despite buf_we.
REQ-040 busy=1 while IDLE with req=2'b01 -> no ack until busy=0.
